// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU micro-sequencer: FSM encoding,
// instruction field layout and the ALU select codes.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Instruction word: {op[7:5], last[4], imm[3:0]}
    localparam int INSTR_W  = 8;
    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 5;
    localparam int LAST_BIT = 4;
    localparam int IMM_MSB  = 3;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

endpackage

// File: rtl/alu_seq_imem.sv
// Instruction store: DEPTH x IW register file, async clear,
// one synchronous write port and one combinational read port.
module alu_seq_imem
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int IW    = INSTR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [IW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [IW-1:0] o_rd_data
);

    logic [IW-1:0] r_mem [DEPTH];

    // NOTE: the store is cleared by reset on purpose, so a run after reset
    // executes a defined all-zero program rather than whatever was left behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Micro-sequencer driving a combinational ALU: runs a small stored program,
// feeding the accumulator back as operand A on every step.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 4,
    parameter int OPW   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [OPW+W:0]     wr_data,
    input  logic               start,
    input  logic [W-1:0]       acc_init,
    output logic               busy,
    output logic               done,
    output logic [W-1:0]       result,
    output logic [AW-1:0]      pc,
    output logic [OPW-1:0]     alu_sel,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    input  logic [W-1:0]       alu_y
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_pc;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_result;
    logic [OPW+W:0]  w_instr;
    logic            w_wr_en;
    logic            w_finish;

    alu_seq_imem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (OPW + 1 + W)
    ) u_imem (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_pc),
        .o_rd_data (w_instr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_finish    = 1'b0;
        alu_sel     = ALU_ADD;
        alu_a       = '0;
        alu_b       = '0;
        case (r_state)
            IDLE: begin
                w_wr_en = wr_en;
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                alu_sel  = w_instr[OP_MSB:OP_LSB];
                alu_a    = r_acc;
                alu_b    = w_instr[IMM_MSB:0];
                // The last slot terminates even without its last bit; pc never wraps.
                w_finish = w_instr[LAST_BIT] || (r_pc == AW'(DEPTH - 1));
                if (w_finish) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc <= acc_init;
                        r_pc  <= '0;
                    end
                end
                RUN: begin
                    r_acc <= alu_y;
                    if (w_finish) begin
                        r_result <= alu_y;
                    end else begin
                        r_pc <= r_pc + AW'(1);
                    end
                end
                DONE:    r_pc <= '0;
                default: r_pc <= '0;
            endcase
        end
    end

    assign busy   = (r_state == RUN) || (r_state == DONE);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign pc     = r_pc;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: expected results and done cycles are
// queued by the driver and checked by an independent monitor on each done.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;
    logic [3:0] acc_init = '0;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic [2:0] pc;
    logic [2:0] alu_sel;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_y;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0] res;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];

    alu_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .acc_init (acc_init),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .pc       (pc),
        .alu_sel  (alu_sel),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_y    (alu_y)
    );

    // Reference ALU: add, subtract, otherwise pass A.
    always_comb begin
        case (alu_sel)
            3'b000:  alu_y = alu_a + alu_b;
            3'b001:  alu_y = alu_a - alu_b;
            default: alu_y = alu_a;
        endcase
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", busy, 1);
            end
        end
    end

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic issue_start(input logic [3:0] init, input logic [3:0] exp_res, input int n);
        start    = 1'b1;
        acc_init = init;
        sb_q.push_back('{exp_res, cyc + n + 2});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic write_slot(input logic [2:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int budget = 40;
        while (sb_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        check(name, sb_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_alu_sel"}, alu_sel, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Power-on reset asserted mid-cycle.
        #2 reset = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Empty memory: 8 slots of add 0, stops at the last slot.
        issue_start(4'b0011, 4'b0011, 7);
        check("empty_busy", busy, 1);
        check("empty_alu_a", alu_a, 4'b0011);
        check("empty_alu_b", alu_b, 0);
        wait_drain("empty_drain");

        // Single step.
        write_slot(3'd0, 8'b000_1_0001);
        issue_start(4'b0110, 4'b0111, 0);
        check("single_sel", alu_sel, 3'b000);
        check("single_a", alu_a, 4'b0110);
        check("single_b", alu_b, 4'b0001);
        wait_drain("single_drain");
        check("idle_alu_a", alu_a, 0);
        check("idle_result_held", result, 4'b0111);

        // Three-step chain; slot 2 written in the same cycle as start.
        write_slot(3'd0, 8'b000_0_0001);
        write_slot(3'd1, 8'b001_0_0011);
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 8'b000_1_1111;
        issue_start(4'b0110, 4'b0011, 2);
        wr_en = 1'b0;
        check("chain_a0", alu_a, 4'b0110);
        check("chain_b0", alu_b, 4'b0001);
        @(negedge clk);
        check("chain_a1", alu_a, 4'b0111);
        check("chain_sel1", alu_sel, 3'b001);
        check("chain_pc1", pc, 1);
        @(negedge clk);
        check("chain_a2", alu_a, 4'b0100);
        check("chain_b2", alu_b, 4'b1111);
        wait_drain("chain_drain");
        repeat (3) @(negedge clk);
        check("result_held_idle", result, 4'b0011);

        // Start and write during RUN must be ignored.
        issue_start(4'b0110, 4'b0011, 2);
        start    = 1'b1;
        acc_init = 4'b1111;
        wr_en    = 1'b1;
        wr_addr  = 3'd1;
        wr_data  = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        check("ign_busy_pc1", busy, 1);
        check("ign_a1", alu_a, 4'b0111);
        @(negedge clk);
        check("ign_busy_pc2", busy, 1);
        @(negedge clk);
        check("ign_busy_done", busy, 1);
        @(negedge clk);
        check("ign_busy_idle", busy, 0);
        wait_drain("ign_drain");

        // Readback run: slot 1 must still be the subtract.
        issue_start(4'b0110, 4'b0011, 2);
        wait_drain("readback_drain");

        // Reset in the second RUN cycle.
        issue_start(4'b0110, 4'b0011, 2);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_pc", pc, 0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Memory now cleared: 8 slots of add 0.
        issue_start(4'b0101, 4'b0101, 7);
        check("cleared_b0", alu_b, 0);
        wait_drain("cleared_drain");

        check("final_queue_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
